// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter (shift-add-3 / double dabble). It
// converts one binary bit per clock. It presents a packed BCD word that
// updates atomically together with a one-cycle done strobe. Inputs above
// MAX_VAL saturate to MAX_VAL and raise ovf.
//
// Optional feature (compile-time macro BIN2BCD_LZ_BLANK_EN):
//   Leading zero digits, excluding digit 0, are replaced by 4'hF. 4'hF is the
//   blank code for the downstream display decoder. With the macro undefined,
//   the output is raw BCD and resets to zero.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, honoured only while busy=0
//   bin_in   in   [BIN_W-1:0] unsigned value, captured on an accepted start
//   busy     out  high while shifting
//   done     out  one-cycle pulse; bcd_out changes in the same cycle
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, units digit in [3:0]
//   ovf      out  input exceeded MAX_VAL; updated with done, held otherwise
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W   = 27,
    parameter int DIGITS  = 8,
    parameter int MAX_VAL = 99999999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int               CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [4*DIGITS-1:0] RESET_BCD = {{(DIGITS-1){4'hF}}, 4'h0};
`else
    localparam logic [4*DIGITS-1:0] RESET_BCD = '0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [BIN_W-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] scratch_adj;
    logic [4*DIGITS-1:0] scratch_shifted;
    logic [4*DIGITS-1:0] bcd_final;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_pending;
    logic                load;
    logic                last_shift;

    // A start is honoured in IDLE and also in DONE. Accepting it in DONE
    // lets a new conversion follow a finished one without a bubble.
    assign load       = start && (state != SHIFT);
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));
    assign busy       = (state == SHIFT);

    // This is one double-dabble step. Each digit that is 5 or more gets +3.
    // The adds are independent 4-bit adds with no carry between digits.
    // After the adds, the binary MSB shifts into the BCD units digit.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_shifted = {scratch_adj[4*DIGITS-2:0], shift_reg[BIN_W-1]};
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic leading;

    // This priority chain runs from the most significant digit downward. It
    // blanks zeros until it reaches the first non-zero digit. Digit 0 always
    // stays visible, so a value of zero displays as a single "0".
    always_comb begin
        bcd_final = scratch_shifted;
        leading   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (scratch_shifted[4*i +: 4] == 4'd0)) begin
                bcd_final[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign bcd_final = scratch_shifted;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The final shift writes its result directly into bcd_out. This makes
    // bcd_out and done change on the same edge. Between those edges, bcd_out
    // is never written, so no partial result is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            bcd_out     <= RESET_BCD;
            ovf         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= last_shift;
            if (load) begin
                shift_reg   <= (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
                ovf_pending <= (bin_in > MAX_BIN);
                scratch     <= '0;
                cnt         <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                shift_reg <= shift_reg << 1;
                scratch   <= scratch_shifted;
                cnt       <= cnt - CNT_W'(1);
                if (last_shift) begin
                    bcd_out <= bcd_final;
                    ovf     <= ovf_pending;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Self-checking bench for bin2bcd_seq. Expected words are computed with
// decimal division when a start is driven and queued. They are popped when
// done fires. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              start  = 1'b0;
    logic [BIN_W-1:0]  bin_in = '0;
    logic              busy;
    logic              done;
    logic [4*DIGITS-1:0] bcd_out;
    logic              ovf;

    int errors = 0;
    int checks = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [31:0] RESET_EXP = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] RESET_EXP = 32'h0000_0000;
`endif

    typedef struct packed {
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    bin2bcd_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_bcd(input logic [BIN_W-1:0] v);
        longint      x;
        logic [31:0] r;
        x = (v > 27'd99999999) ? 64'd99999999 : longint'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BIN2BCD_LZ_BLANK_EN
        for (int i = 7; i >= 1; i--) begin
            if (r[4*i +: 4] != 4'd0) break;
            r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // This task is called on a falling edge while the DUT can accept. It
    // returns on the next falling edge, which is cycle 1 of the conversion.
    task automatic send(input logic [BIN_W-1:0] v);
        exp_t e;
        e.bcd = model_bcd(v);
        e.ovf = (v > 27'd99999999);
        sb.push_back(e);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // This task waits for done and scrambles bin_in while it waits. It
    // returns the falling-edge count since acceptance and whether the wait
    // ran out of cycles.
    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            bin_in = BIN_W'($urandom);
            @(negedge clk);
            cyc++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (bcd_out !== RESET_EXP) begin errors++; $display("[TB] FAIL reset_bcd: got %h expected %h", bcd_out, RESET_EXP); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency_zero;
        int   cyc;
        int   busy_hi;
        exp_t e;
        send(0);
        cyc = 1; busy_hi = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 28) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 28", cyc); end
        checks++; if (busy_hi !== 27) begin errors++; $display("[TB] FAIL zero_busy_cycles: got %0d expected 27", busy_hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_at_done: got %b expected 0", busy); end
        e = sb.pop_front();
        checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL zero_bcd: got %h expected %h", bcd_out, e.bcd); end
        checks++; if (ovf !== e.ovf) begin errors++; $display("[TB] FAIL zero_ovf: got %b expected %b", ovf, e.ovf); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_values;
        logic [BIN_W-1:0] vals[7];
        logic [31:0]      prev;
        bit               held;
        int               cyc;
        exp_t             e;
        vals = '{27'd12345678, 27'd99999999, 27'd100000000, 27'h7FFFFFF,
                 27'd5, 27'd10000000, 27'd42};
        prev = model_bcd(0);
        foreach (vals[k]) begin
            send(vals[k]);
            cyc = 1; held = 1'b1;
            while (done !== 1'b1 && cyc < 60) begin
                if (bcd_out !== prev) held = 1'b0;
                bin_in = BIN_W'($urandom);
                @(negedge clk);
                cyc++;
            end
            checks++; if (cyc !== 28) begin errors++; $display("[TB] FAIL value_latency[%0d]: got %0d expected 28", k, cyc); end
            checks++; if (held !== 1'b1) begin errors++; $display("[TB] FAIL value_hold[%0d]: got changed expected held %h", k, prev); end
            if (sb.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL value_queue[%0d]: got empty expected entry", k);
            end else begin
                e = sb.pop_front();
                checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL value_bcd[%0d]: got %h expected %h", k, bcd_out, e.bcd); end
                checks++; if (ovf !== e.ovf) begin errors++; $display("[TB] FAIL value_ovf[%0d]: got %b expected %b", k, ovf, e.ovf); end
                prev = e.bcd;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int   cyc;
        int   done_seen;
        bit   to;
        exp_t e;
        send(42);
        cyc = 1; done_seen = 0;
        while (done !== 1'b1 && cyc < 60) begin
            start  = (cyc == 5 || cyc == 20);
            bin_in = 27'd777;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc !== 28) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 28", cyc); end
        e = sb.pop_front();
        checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL ignore_bcd: got %h expected %h", bcd_out, e.bcd); end
        send(7);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
        checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL b2b_hold: got %h expected %h", bcd_out, e.bcd); end
        wait_done(cyc, to);
        checks++; if (to || cyc !== 28) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 28", cyc); end
        e = sb.pop_front();
        checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL b2b_bcd: got %h expected %h", bcd_out, e.bcd); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy); end
        // Pass A and the stray starts would each have produced an extra done.
        repeat (30) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL ignore_no_queue: got %0d dones expected 0", done_seen); end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        int   done_seen;
        bit   to;
        exp_t e;
        send(27'd100000000);
        wait_done(cyc, to);
        e = sb.pop_front();
        checks++; if (to || ovf !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf: got %b expected 1", ovf); end
        @(negedge clk);
        send(27'd123456);
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_done: got %b expected 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ovf: got %b expected 0", ovf); end
        checks++; if (bcd_out !== RESET_EXP) begin errors++; $display("[TB] FAIL mid_reset_bcd: got %h expected %h", bcd_out, RESET_EXP); end
        void'(sb.pop_back());
        done_seen = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d expected 0", done_seen); end
        send(27'd900);
        wait_done(cyc, to);
        checks++; if (to || cyc !== 28) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 28", cyc); end
        e = sb.pop_front();
        checks++; if (bcd_out !== e.bcd) begin errors++; $display("[TB] FAIL post_reset_bcd: got %h expected %h", bcd_out, e.bcd); end
        checks++; if (ovf !== e.ovf) begin errors++; $display("[TB] FAIL post_reset_ovf: got %b expected %b", ovf, e.ovf); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_latency_zero();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
